// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types for the instruction/data memory arbiter.
// Revision 1.0
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    // Keeps the wait counter at least one bit wide even when MAX_DWAIT is 0.
    function automatic int wcnt_w(input int max_dwait);
        return (max_dwait < 1) ? 1 : $clog2(max_dwait + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and memory handshake bundle.
// Revision 1.0
`default_nettype none

interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rdata;
    logic            if_ack;

    logic            dm_req;
    logic            dm_we;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic [DW/8-1:0] dm_be;
    logic [DW-1:0]   dm_rdata;
    logic            dm_ack;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ready;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_rdata, dm_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_rdata, dm_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ready
    );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data requests onto one single-port memory.
// Revision 1.0
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_DWAIT = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mem_arbiter_if.master   bus,
    output logic            busy
);

    localparam int              WCNT_W   = wcnt_w(MAX_DWAIT);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_DWAIT);
    localparam int              BEW      = DW / 8;

    state_t            state;
    owner_t            owner;
    logic [WCNT_W-1:0] wait_cnt;

    logic              grant_data;
    logic              grant_inst;
    logic [AW-1:0]     gnt_addr;
    logic [DW-1:0]     gnt_wdata;
    logic [BEW-1:0]    gnt_be;
    logic              gnt_we;

    // Data wins unless fetch has already waited out MAX_DWAIT data grants.
    assign grant_data = bus.dm_req && (!bus.if_req || (wait_cnt < WCNT_MAX));
    assign grant_inst = bus.if_req && !grant_data;

    always_comb begin
        gnt_addr  = bus.if_addr;
        gnt_wdata = bus.dm_wdata;
        gnt_be    = {BEW{1'b1}};
        gnt_we    = 1'b0;
        if (grant_data) begin
            gnt_addr = bus.dm_addr;
            gnt_be   = bus.dm_be;
            gnt_we   = bus.dm_we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            owner         <= OWN_DATA;
            wait_cnt      <= '0;
            busy          <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            bus.if_ack    <= 1'b0;
            bus.dm_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data || grant_inst) begin
                        state         <= BUSY;
                        busy          <= 1'b1;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= gnt_we;
                        bus.mem_addr  <= gnt_addr;
                        bus.mem_wdata <= gnt_wdata;
                        bus.mem_be    <= gnt_be;
                        owner         <= grant_data ? OWN_DATA : OWN_INST;
                        if (grant_data && bus.if_req) begin
                            if (wait_cnt != WCNT_MAX) begin
                                wait_cnt <= wait_cnt + WCNT_W'(1);
                            end
                        end else begin
                            wait_cnt <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        state       <= RESP;
                        bus.mem_req <= 1'b0;
                        if (owner == OWN_INST) begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_ack   <= 1'b1;
                        end else begin
                            bus.dm_rdata <= bus.mem_rdata;
                            bus.dm_ack   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    // No arbitration here so a request still held during its ack is not reissued.
                    state      <= IDLE;
                    busy       <= 1'b0;
                    bus.if_ack <= 1'b0;
                    bus.dm_ack <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Revision 1.0
`default_nettype none

module tb_mem_arbiter;

    localparam int MAXD = 2;

    logic clk;
    logic reset;
    logic busy;
    int   n_chk;
    int   n_err;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .MAX_DWAIT(MAXD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one transaction at a time, tracked as grant -> memory wait -> ack cycle.
    logic        m_mem_req, m_we, m_if_ack, m_dm_ack, m_busy, m_owner_data;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
    logic [3:0]  m_be;
    int          m_waits;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mem_req = 0; m_we = 0; m_if_ack = 0; m_dm_ack = 0; m_busy = 0;
            m_owner_data = 1; m_addr = 0; m_wdata = 0; m_be = 0;
            m_if_rdata = 0; m_dm_rdata = 0; m_waits = 0;
        end else if (m_if_ack || m_dm_ack) begin
            m_if_ack = 0;
            m_dm_ack = 0;
            m_busy   = 0;
        end else if (m_mem_req) begin
            if (bus.mem_ready) begin
                m_mem_req = 0;
                if (m_owner_data) begin
                    m_dm_ack = 1; m_dm_rdata = bus.mem_rdata;
                end else begin
                    m_if_ack = 1; m_if_rdata = bus.mem_rdata;
                end
            end
        end else if (bus.dm_req && (!bus.if_req || m_waits < MAXD)) begin
            m_mem_req = 1; m_busy = 1; m_owner_data = 1;
            m_addr = bus.dm_addr; m_we = bus.dm_we; m_wdata = bus.dm_wdata; m_be = bus.dm_be;
            m_waits = bus.if_req ? ((m_waits + 1 > MAXD) ? MAXD : m_waits + 1) : 0;
        end else if (bus.if_req) begin
            m_mem_req = 1; m_busy = 1; m_owner_data = 0;
            m_addr = bus.if_addr; m_we = 0; m_be = 4'hF;
            m_waits = 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("busy", busy, m_busy);
            check("mem_req", bus.mem_req, m_mem_req);
            check("if_ack", bus.if_ack, m_if_ack);
            check("dm_ack", bus.dm_ack, m_dm_ack);
            check("if_rdata", bus.if_rdata, m_if_rdata);
            check("dm_rdata", bus.dm_rdata, m_dm_rdata);
            check("ack_exclusive", bus.if_ack & bus.dm_ack, 0);
            if (m_mem_req) begin
                check("mem_addr", bus.mem_addr, m_addr);
                check("mem_we", bus.mem_we, m_we);
                check("mem_be", bus.mem_be, m_be);
                if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
            end
        end
    end

    initial begin
        int   ng;
        logic prev;
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_be = 0;
        bus.mem_rdata = 0; bus.mem_ready = 0;
        #12;
        check("reset_mem_req", bus.mem_req, 0);
        check("reset_busy", busy, 0);
        check("reset_acks", {bus.if_ack, bus.dm_ack}, 0);
        #10 reset = 1'b1;
        tick();

        // Single fetch at minimum latency
        bus.if_req = 1; bus.if_addr = 32'h100; bus.mem_ready = 1; bus.mem_rdata = 32'h00500093;
        tick();
        check("fetch_c1_mem_req", bus.mem_req, 1);
        check("fetch_c1_mem_addr", bus.mem_addr, 32'h100);
        check("fetch_c1_mem_we", bus.mem_we, 0);
        tick();
        check("fetch_c2_if_ack", bus.if_ack, 1);
        check("fetch_c2_if_rdata", bus.if_rdata, 32'h00500093);
        bus.if_req = 0;
        tick();
        check("fetch_c3_busy", busy, 0);
        check("fetch_c3_if_ack", bus.if_ack, 0);
        bus.mem_ready = 0;

        // Store with three wait states
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h2004; bus.dm_wdata = 32'hDEADBEEF; bus.dm_be = 4'b0011;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("store_mem_req", bus.mem_req, 1);
            check("store_mem_addr", bus.mem_addr, 32'h2004);
            check("store_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
            check("store_mem_be", bus.mem_be, 4'b0011);
            check("store_mem_we", bus.mem_we, 1);
            check("store_early_ack", bus.dm_ack, 0);
            if (k == 2) bus.mem_ready = 1;
            tick();
        end
        check("store_dm_ack", bus.dm_ack, 1);
        check("store_if_ack", bus.if_ack, 0);
        check("store_mem_req_drop", bus.mem_req, 0);
        bus.dm_req = 0; bus.mem_ready = 0;
        tick();
        check("store_ack_once", bus.dm_ack, 0);
        check("store_idle", busy, 0);

        // Collision: data first, fetch right after the data ack cycle
        bus.if_req = 1; bus.if_addr = 32'h4000;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h3000; bus.mem_ready = 1;
        tick();
        check("coll_first_data", bus.mem_addr, 32'h3000);
        tick();
        check("coll_dm_ack", bus.dm_ack, 1);
        bus.dm_req = 0;
        tick();
        check("coll_idle", busy, 0);
        tick();
        check("coll_fetch_req", bus.mem_req, 1);
        check("coll_fetch_addr", bus.mem_addr, 32'h4000);
        tick();
        check("coll_if_ack", bus.if_ack, 1);
        bus.if_req = 0;
        tick();
        tick();

        // Starvation guard with MAX_DWAIT=2: D, D, I repeating
        bus.if_req = 1; bus.if_addr = 32'h1000;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h2000; bus.mem_ready = 1;
        ng = 0;
        prev = 0;
        for (int c = 0; c < 18; c++) begin
            tick();
            if (bus.mem_req && !prev) begin
                if (ng < 6) begin
                    check("starve_grant_is_inst", bus.mem_addr == 32'h1000, (ng % 3) == 2);
                    if (bus.mem_addr == 32'h1000) check("starve_wait_cnt_clear", dut.wait_cnt, 0);
                end
                ng++;
            end
            prev = bus.mem_req;
        end
        check("starve_grant_count", ng, 6);
        bus.if_req = 0; bus.dm_req = 0; bus.mem_ready = 0;
        tick();
        tick();

        // Flush: data request withdrawn during the second BUSY cycle
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h5000;
        tick();
        tick();
        bus.dm_req = 0; bus.mem_ready = 1;
        tick();
        check("flush_dm_ack", bus.dm_ack, 1);
        tick();
        check("flush_idle", busy, 0);
        check("flush_no_grant", bus.mem_req, 0);
        tick();
        check("flush_no_grant2", bus.mem_req, 0);
        bus.mem_ready = 0;

        // Asynchronous reset while BUSY
        bus.dm_req = 1; bus.dm_addr = 32'h6000;
        tick();
        tick();
        check("rst_pre_mem_req", bus.mem_req, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_mem_req", bus.mem_req, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_acks", {bus.if_ack, bus.dm_ack}, 0);
        bus.dm_req = 0;
        #2 reset = 1'b1;
        bus.if_req = 1; bus.if_addr = 32'h500; bus.mem_ready = 1;
        tick();
        check("rst_after_req", bus.mem_req, 1);
        check("rst_after_addr", bus.mem_addr, 32'h500);
        tick();
        check("rst_after_ack", bus.if_ack, 1);
        bus.if_req = 0;
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!bus.if_req) begin
                if ($urandom_range(0, 2) == 0) begin bus.if_req = 1; bus.if_addr = $urandom; end
            end else if (bus.if_ack) begin
                if ($urandom_range(0, 1) == 0) bus.if_req = 0;
                else bus.if_addr = $urandom;
            end else if ($urandom_range(0, 29) == 0) begin
                bus.if_req = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.if_addr = $urandom;
            end
            if (!bus.dm_req) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.dm_req = 1; bus.dm_we = 1'($urandom); bus.dm_addr = $urandom;
                    bus.dm_wdata = $urandom; bus.dm_be = 4'($urandom);
                end
            end else if (bus.dm_ack) begin
                if ($urandom_range(0, 1) == 0) bus.dm_req = 0;
                else begin bus.dm_addr = $urandom; bus.dm_wdata = $urandom; end
            end else if ($urandom_range(0, 29) == 0) begin
                bus.dm_req = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.dm_wdata = $urandom; bus.dm_be = 4'($urandom);
            end
            bus.mem_ready = ($urandom_range(0, 2) == 0);
            bus.mem_rdata = $urandom;
            tick();
        end
        bus.if_req = 0; bus.dm_req = 0; bus.mem_ready = 1;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the pipelined core's instruction-fetch port and its data (load/store) port.
- Serialises requests, one transaction in flight at a time, and drives the ready/valid handshake toward memory.
- Returns a one-cycle acknowledge with read data; the hazard logic uses that acknowledge to stall the Fetch and Memory stages.
- Data has priority; a wait counter stops instruction fetch from starving.

Parameters:
AW, 32, address width
DW, 32, data width; DW/8 byte enables
MAX_DWAIT, 4, number of consecutive data grants with fetch pending before fetch is forced through

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset (0 = reset)
if_req  in  1  fetch request, held until if_ack
if_addr  in  AW  fetch address
if_rdata  out  DW  fetched instruction, valid while if_ack=1
if_ack  out  1  one-cycle fetch completion pulse
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_be  in  DW/8  store byte enables
dm_rdata  out  DW  load data, valid while dm_ack=1
dm_ack  out  1  one-cycle data completion pulse
mem_req  out  1  memory request valid
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_be  out  DW/8  memory byte enables
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current request on this edge
busy  out  1  a transaction is in progress (state != IDLE)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; wait_cnt=0; owner=DATA; all outputs 0. A transaction in flight is abandoned: mem_req drops immediately and no ack is issued.
- All outputs are registered.
- States:
  - IDLE: arbitration.
  - BUSY: mem_req=1, waiting for mem_ready.
  - RESP: ack pulse.
- IDLE arbitration, decided on the clock edge:
  - dm_req=1 and (if_req=0 or wait_cnt<MAX_DWAIT) -> grant DATA.
  - else if_req=1 -> grant INST.
  - else stay in IDLE.
- On a grant:
  - The request fields are latched into mem_addr/mem_we/mem_wdata/mem_be.
  - INST grants force mem_we=0 and mem_be=all ones.
  - mem_req=1 from the next cycle; go to BUSY.
- wait_cnt:
  - DATA grant with if_req=1: increment, saturating at MAX_DWAIT.
  - Any INST grant: clear to 0.
  - DATA grant with if_req=0: clear to 0.
- BUSY:
  - The mem_* outputs are held stable until mem_ready=1 is sampled.
  - On that edge: mem_req->0; mem_rdata is captured into if_rdata or dm_rdata according to owner; the owner's ack->1; go to RESP.
  - Stores also capture rdata; the value is don't-care.
- RESP:
  - Ack is high for exactly this cycle, then ->0; go to IDLE.
  - No grant is made in RESP, so a request still held in its ack cycle is never re-issued.
- Minimum latency, mem_ready high in the first BUSY cycle: req sampled at edge 0 -> mem_req at cycle 1 -> ack at cycle 2 -> IDLE at cycle 3. Peak rate is 1 transaction per 3 cycles.
- mem_ready while not in BUSY is ignored.
- Rdata outputs hold their last captured value after the ack.
- Requester drops req mid-transaction (flush): the transaction still completes and the ack is still pulsed; the requester ignores it.
- Requester changes addr/data mid-transaction: no effect, because the fields were latched at grant.
- Both acks are never high in the same cycle.
- Simultaneous if_req and dm_req in IDLE follow the priority rule above.
- MAX_DWAIT=0: fetch always wins over data when both are pending.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY, RESP}
  - owner enum {OWN_INST, OWN_DATA}
  - WCNT_W = $clog2(MAX_DWAIT+1) as a function or localparam
- No sub-module needed: one FSM, one saturating counter, output registers.
- The existing flopr-style registers may be reused for the rdata capture.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; memory gives mem_ready=1 on the first BUSY cycle with mem_rdata=0x00500093. Required: mem_req=1 at cycle 1 with mem_addr=0x100 and mem_we=0; if_ack=1 with if_rdata=0x00500093 at cycle 2; busy=0 at cycle 3.
- Store with wait states: dm_req=1, dm_we=1, dm_addr=0x2004, dm_wdata=0xDEADBEEF, dm_be=4'b0011; mem_ready asserted after 3 BUSY cycles. Required: mem_* stable for all 3 cycles; dm_ack pulses exactly once, one cycle after mem_ready; if_ack stays 0.
- Collision: if_req and dm_req asserted together, MAX_DWAIT=4. Required: data granted first; fetch granted immediately after that data transaction's RESP cycle.
- Starvation: if_req held, dm_req re-asserted continuously, MAX_DWAIT=2. Required: grant order D, D, I, D, D, I; wait_cnt clears on each I grant.
- Flush: dm_req dropped in the second BUSY cycle. Required: transaction completes and dm_ack pulses; no new grant until IDLE.
- Reset mid-BUSY: reset=0 while mem_req=1. Required: mem_req, acks and busy go to 0 asynchronously without waiting for clk; after release, an if_req is granted normally.
